alu_flag_wb: RTL and testbench

- Execute-to-writeback stage that sits directly downstream of the ADD/ALU datapath.
- Accepts each ALU result with its candidate NZCV flags, S bit, destination register and condition code.
- Evaluates the condition against the architectural NZCV register and commits the flags when S=1 and the condition passes.
- Buffers results in a small FIFO toward register-file writeback; flags_q is fed back as the ALU's Flag input.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/cond_eval.sv | 39 +++
 rtl/alu_flag_wb.sv | 109 ++++++++++
 tb/tb_alu_flag_wb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, condition codes and the flags type.
package alu_pkg;

  localparam int unsigned N_BIT = 3;
  localparam int unsigned Z_BIT = 2;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned V_BIT = 0;

  typedef logic [3:0] flags_t;
  typedef logic [3:0] cond_t;

  localparam cond_t COND_EQ = 4'h0;
  localparam cond_t COND_NE = 4'h1;
  localparam cond_t COND_CS = 4'h2;
  localparam cond_t COND_CC = 4'h3;
  localparam cond_t COND_MI = 4'h4;
  localparam cond_t COND_PL = 4'h5;
  localparam cond_t COND_VS = 4'h6;
  localparam cond_t COND_VC = 4'h7;
  localparam cond_t COND_HI = 4'h8;
  localparam cond_t COND_LS = 4'h9;
  localparam cond_t COND_GE = 4'hA;
  localparam cond_t COND_LT = 4'hB;
  localparam cond_t COND_GT = 4'hC;
  localparam cond_t COND_LE = 4'hD;
  localparam cond_t COND_AL = 4'hE;
  localparam cond_t COND_NV = 4'hF;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator against an NZCV flag set.
module cond_eval
  import alu_pkg::*;
(
  input  cond_t  cond_i,
  input  flags_t flags_i,
  output logic   pass_o
);

  logic n, z, c, v;

  assign n = flags_i[N_BIT];
  assign z = flags_i[Z_BIT];
  assign c = flags_i[C_BIT];
  assign v = flags_i[V_BIT];

  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c & !z;
      COND_LS: pass_o = !c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_wb.sv
// Execute-to-writeback stage: conditional flag commit plus an ordered result FIFO.
module alu_flag_wb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RD_W  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_result,
  input  flags_t                  in_flags,
  input  logic                    in_s,
  input  logic [RD_W-1:0]         in_rd,
  input  cond_t                   in_cond,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]         out_rd,
  output logic                    out_we,
  output flags_t                  flags_q,
  output logic [CNT_W-1:0]        fail_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_FW = $clog2(DEPTH + 1);
  localparam logic [CNT_FW-1:0] FULL = CNT_FW'(DEPTH);

  logic signed [WIDTH-1:0] mem_result [DEPTH];
  logic [RD_W-1:0]         mem_rd     [DEPTH];
  logic                    mem_we     [DEPTH];

  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  flags_t            flags_d;
  logic              pass, push, pop;

  cond_eval u_cond_eval (
    .cond_i  (in_cond),
    .flags_i (flags_q),
    .pass_o  (pass)
  );

  // in_ready depends only on the registered count, never on out_ready.
  assign in_ready  = (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_result = out_valid ? mem_result[rptr_q] : '0;
  assign out_rd     = out_valid ? mem_rd[rptr_q]     : '0;
  assign out_we     = out_valid ? mem_we[rptr_q]     : 1'b0;
  assign fail_cnt   = fail_cnt_q;

  always_comb begin
    flags_d    = flags_q;
    fail_cnt_d = fail_cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (push) begin
      wptr_d = wptr_q + PTR_W'(1);
      if (pass && in_s) begin
        flags_d = in_flags;
      end
      if (!pass && (fail_cnt_q != '1)) begin
        fail_cnt_d = fail_cnt_q + CNT_W'(1);
      end
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q    <= '0;
      fail_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      flags_q    <= flags_d;
      fail_cnt_q <= fail_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; the empty-gated outputs hide stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wptr_q] <= in_result;
      mem_rd[wptr_q]     <= in_rd;
      mem_we[wptr_q]     <= pass;
    end
  end

endmodule

// File: tb/tb_alu_flag_wb.sv
// Directed and randomized bench for alu_flag_wb against a queue-based reference model.
module tb_alu_flag_wb;
  import alu_pkg::*;

  localparam int DEPTH = 2;

  logic               clk, rst;
  logic               in_valid, in_ready, in_s;
  logic signed [31:0] in_result, out_result;
  logic [3:0]         in_flags, in_rd, in_cond, out_rd, flags_q;
  logic               out_valid, out_ready, out_we;
  logic [15:0]        fail_cnt;

  alu_flag_wb #(.WIDTH(32), .DEPTH(DEPTH), .RD_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_flags   (in_flags),
    .in_s       (in_s),
    .in_rd      (in_rd),
    .in_cond    (in_cond),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_we     (out_we),
    .flags_q    (flags_q),
    .fail_cnt   (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  rd;
    logic        we;
  } entry_t;

  entry_t      mq[$];
  logic [3:0]  mflags;
  logic [15:0] mfail;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Conditions come in complementary pairs: even code tests, odd code inverts.
  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check_outputs();
    bit nonempty;
    nonempty = (mq.size() != 0);
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(nonempty));
    chk("out_result", out_result, nonempty ? mq[0].result : 32'd0);
    chk("out_rd", 32'(out_rd), nonempty ? 32'(mq[0].rd) : 32'd0);
    chk("out_we", 32'(out_we), nonempty ? 32'(mq[0].we) : 32'd0);
    chk("flags_q", 32'(flags_q), 32'(mflags));
    chk("fail_cnt", 32'(fail_cnt), 32'(mfail));
  endtask

  // One clock: drive, check before the edge, then advance the model at the edge.
  task automatic cycle(input logic v, input logic [31:0] res, input logic [3:0] fl,
                       input logic s, input logic [3:0] rd, input logic [3:0] cond,
                       input logic ordy, output bit acc);
    bit pass, popm;
    in_valid = v; in_result = res; in_flags = fl; in_s = s;
    in_rd = rd; in_cond = cond; out_ready = ordy;
    #1;
    check_outputs();
    acc  = v && (mq.size() < DEPTH);
    pass = ref_cond(cond, mflags);
    popm = (mq.size() != 0) && ordy;
    @(posedge clk);
    if (popm) void'(mq.pop_front());
    if (acc) begin
      mq.push_back('{result: res, rd: rd, we: pass});
      if (pass && s) mflags = fl;
      if (!pass && mfail != 16'hFFFF) mfail++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    bit a;
    cycle(1'b0, 32'd0, 4'd0, 1'b0, 4'd0, COND_AL, ordy, a);
  endtask

  initial begin
    bit a;
    int tries;
    rst = 1'b1; in_valid = 0; in_result = 0; in_flags = 0; in_s = 0;
    in_rd = 0; in_cond = 0; out_ready = 0;
    mflags = 4'b0000; mfail = 16'd0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;
    idle(1'b1);

    // Two flag-setting AL ops streaming through.
    cycle(1, 32'd5, 4'b0000, 1, 4'd1, COND_AL, 1, a);
    cycle(1, -32'sd8, 4'b1010, 1, 4'd2, COND_AL, 1, a);
    idle(1); idle(1);
    chk("flags_after_stream", 32'(flags_q), 32'hA);

    // EQ passes on Z=1, NE fails.
    cycle(1, 32'd0, 4'b0110, 1, 4'd3, COND_AL, 1, a);
    cycle(1, 32'd7, 4'b1111, 0, 4'd4, COND_EQ, 1, a);
    cycle(1, 32'd9, 4'b1111, 0, 4'd5, COND_NE, 1, a);
    idle(1); idle(1);
    chk("flags_eq_ne", 32'(flags_q), 32'h6);
    chk("fail_one", 32'(fail_cnt), 32'd1);

    // S=0 must not commit.
    cycle(1, -32'sd1, 4'b1000, 0, 4'd6, COND_AL, 1, a);
    idle(1);
    chk("flags_s0", 32'(flags_q), 32'h6);

    // Backpressure: third op is held until space frees.
    cycle(1, 32'h11, 4'b0110, 0, 4'd7, COND_AL, 0, a);
    cycle(1, 32'h22, 4'b0110, 0, 4'd8, COND_AL, 0, a);
    cycle(1, 32'h33, 4'b0110, 0, 4'd9, COND_AL, 0, a);
    chk("third_held", 32'(a), 32'd0);
    tries = 0;
    do begin
      cycle(1, 32'h33, 4'b0110, 0, 4'd9, COND_AL, 1, a);
      tries++;
    end while (!a && tries < 6);
    chk("third_accepted", 32'(a), 32'd1);
    repeat (3) idle(1);

    // Push and pop together at count=1, wrapping both pointers.
    cycle(1, 32'h100, 4'b0000, 0, 4'd0, COND_AL, 0, a);
    for (int i = 1; i <= 10; i++)
      cycle(1, 32'h100 + 32'(i), 4'b0000, 0, 4'(i), COND_AL, 1, a);
    chk("count_one", 32'(mq.size()), 32'd1);
    idle(1); idle(1);

    // Asynchronous reset with two entries queued and nonzero state.
    cycle(1, 32'hAA, 4'b1111, 1, 4'd1, COND_AL, 0, a);
    cycle(1, 32'hBB, 4'b0000, 0, 4'd2, COND_NV, 0, a);
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_fail", 32'(fail_cnt), 32'd0);
    chk("rst_result", out_result, 32'd0);
    mq.delete(); mflags = 4'b0000; mfail = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, 4'($urandom), 1'($urandom),
            4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0), a);
    repeat (3) idle(1);

    // Saturate the fail counter.
    mfail = 16'hFFFF;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); mflags = 4'b0000; mfail = 16'd0;
    for (int i = 0; i < 65537; i++)
      cycle(1, 32'(i), 4'b0000, 0, 4'(i), COND_NV, 1, a);
    idle(1);
    chk("fail_saturated", 32'(fail_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
